// File: rtl/vga_line_fetcher_if.sv
// rtl/vga_line_fetcher_if.sv - single-outstanding framebuffer read port
interface vga_line_fetcher_if #(
   parameter int ADDR_W = 17
) ();
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [7:0]        mem_rdata;

   modport master (
      output mem_req, mem_addr,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/vga_line_fetcher.sv
// rtl/vga_line_fetcher.sv - ping-pong line fetcher with 2x pixel doubling for the VGA driver
// Optional checkerboard test pattern: VGA_LINE_FETCH_PATTERN_EN
module vga_line_fetcher #(
   parameter int SRC_W  = 320,
   parameter int SRC_H  = 240,
   parameter int ADDR_W = 17
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [9:0]           next_x,
   input  logic [9:0]           next_y,
   input  logic                 vsync,
`ifdef VGA_LINE_FETCH_PATTERN_EN
   input  logic                 pattern_sel,
`endif
   vga_line_fetcher_if.master   mem,
   output logic [7:0]           color_out,
   output logic                 busy,
   output logic                 underrun
);
   localparam int COL_W = $clog2(SRC_W);
   localparam int ROW_W = $clog2(SRC_H);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(SRC_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

   state_t            state;
   logic              vsync_q;
   logic [9:0]        y_q;
   logic [ROW_W-1:0]  target;
   logic [COL_W-1:0]  col;
   logic              abort_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;

   logic [7:0] bank0 [0:SRC_W-1];
   logic [7:0] bank1 [0:SRC_W-1];

   logic [8:0]        src_col, src_row;
   logic              y_changed, frame_ev, line_ev, need_ev, start_ev;
   logic              accept, hit_need, col_in_range, wr_en, pat_on;
   logic [ROW_W-1:0]  new_target, start_row;
   logic [ADDR_W-1:0] start_base;
   logic              unused_bits;

   assign unused_bits = next_x[0];
   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;

`ifdef VGA_LINE_FETCH_PATTERN_EN
   assign pat_on = pattern_sel;
`else
   assign pat_on = 1'b0;
`endif

   assign src_col      = next_x[9:1];
   assign src_row      = next_y[9:1];
   assign y_changed    = (next_y != y_q);
   assign frame_ev     = vsync_q && !vsync;
   assign line_ev      = y_changed && next_y[0] && ((10'(src_row) + 10'd1) < 10'(SRC_H));
   assign need_ev      = y_changed && !next_y[0] && (next_y != 10'd0);
   assign start_ev     = frame_ev || line_ev;
   assign new_target   = frame_ev ? '0 : ROW_W'(src_row + 9'd1);
   assign accept       = req_q && mem.mem_ready;
   assign hit_need     = need_ev && busy && (10'(target) == 10'(src_row));
   assign col_in_range = 10'(src_col) < 10'(SRC_W);

   // A drained fetch restarts the pending row unless a newer event replaces it this cycle.
   assign start_row  = (state == S_DRAIN && !start_ev) ? target : new_target;
   assign start_base = ADDR_W'(start_row) * ADDR_W'(SRC_W);

   assign wr_en = (state == S_WAIT) && mem.mem_rvalid && !start_ev && !reset;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         if (target[0]) bank1[col] <= mem.mem_rdata;
         else           bank0[col] <= mem.mem_rdata;
      end
   end

   always_comb begin
      color_out = 8'h00;
      if (pat_on)
         color_out = (next_x[5] ^ next_y[5]) ? 8'hFF : 8'h00;
      else if (col_in_range)
         color_out = src_row[0] ? bank1[COL_W'(src_col)] : bank0[COL_W'(src_col)];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         vsync_q  <= 1'b1;
         y_q      <= '0;
         target   <= '0;
         col      <= '0;
         abort_q  <= 1'b0;
         req_q    <= 1'b0;
         addr_q   <= '0;
         busy     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         vsync_q <= vsync;
         y_q     <= next_y;
         if (hit_need && !pat_on) underrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start_ev) begin
                  target <= new_target;
                  col    <= '0;
                  addr_q <= start_base;
                  req_q  <= 1'b1;
                  busy   <= 1'b1;
                  state  <= S_REQ;
               end
            end
            S_REQ: begin
               if (start_ev) begin
                  target  <= new_target;
                  abort_q <= 1'b1;
               end
               // An issued request must still be accepted; its response is drained later.
               if (accept) begin
                  req_q   <= 1'b0;
                  abort_q <= 1'b0;
                  state   <= (abort_q || start_ev) ? S_DRAIN : S_WAIT;
               end
            end
            S_WAIT: begin
               if (start_ev) begin
                  target <= new_target;
                  if (mem.mem_rvalid) begin
                     col    <= '0;
                     addr_q <= start_base;
                     req_q  <= 1'b1;
                     state  <= S_REQ;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (mem.mem_rvalid) begin
                  if (col == LAST_COL) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     col    <= col + 1'b1;
                     addr_q <= addr_q + 1'b1;
                     req_q  <= 1'b1;
                     state  <= S_REQ;
                  end
               end
            end
            S_DRAIN: begin
               if (start_ev) target <= new_target;
               if (mem.mem_rvalid) begin
                  col    <= '0;
                  addr_q <= start_base;
                  req_q  <= 1'b1;
                  state  <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_line_fetcher.sv
// tb/tb_vga_line_fetcher.sv - scoreboard bench for vga_line_fetcher
module tb_vga_line_fetcher;
   localparam int SRC_W  = 320;
   localparam int SRC_H  = 240;
   localparam int ADDR_W = 17;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] next_x = '0;
   logic [9:0] next_y = '0;
   logic       vsync = 1'b1;
   logic [7:0] color_out;
   logic       busy, underrun;

   vga_line_fetcher_if #(.ADDR_W(ADDR_W)) mif ();

   vga_line_fetcher #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .next_x    (next_x),
      .next_y    (next_y),
      .vsync     (vsync),
      .mem       (mif),
      .color_out (color_out),
      .busy      (busy),
      .underrun  (underrun)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [ADDR_W-1:0] exp_q [$];
   logic [7:0]        ref_buf [2][SRC_W];
   logic [7:0]        seed = 8'h00;
   int                lat = 1;
   bit                force_low = 1'b0;
   bit                rand_ready = 1'b0;

   logic [ADDR_W-1:0] mem_q_addr [$];
   int                mem_q_due [$];
   int                last_due = 0;
   int                due;
   logic [ADDR_W-1:0] mon_e;
   logic [ADDR_W-1:0] resp_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_data(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ seed;
   endfunction

   task automatic push_row(input int row);
      for (int c = 0; c < SRC_W; c++) exp_q.push_back(ADDR_W'(row * SRC_W + c));
   endtask

   task automatic fill_ref(input int row, input int ncols);
      for (int c = 0; c < ncols; c++) ref_buf[row % 2][c] = mem_data(ADDR_W'(row * SRC_W + c));
   endtask

   function automatic logic [7:0] exp_color(input logic [9:0] x, input logic [9:0] y);
      int col;
      col = int'(x) / 2;
      if (col >= SRC_W) return 8'h00;
      return ref_buf[(int'(y) / 2) % 2][col];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic probe(input logic [9:0] x, input logic [9:0] y);
      tick();
      next_x = x;
      next_y = y;
      @(negedge clock);
      check("color", {24'h0, color_out}, {24'h0, exp_color(x, y)});
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clock);
      while (busy && n < budget) begin
         @(negedge clock);
         n++;
      end
      check("busy_fall", {31'h0, busy}, 32'h0);
   endtask

   task automatic wait_req(input int budget);
      int n;
      n = 0;
      @(negedge clock);
      while (!mif.mem_req && n < budget) begin
         @(negedge clock);
         n++;
      end
      check("req_rise", {31'h0, mif.mem_req}, 32'h1);
   endtask

   // Memory: accepts at the edge after a negedge showing req&&ready, answers in order after lat cycles.
   initial begin
      mif.mem_ready  = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = 8'h00;
      forever begin
         @(negedge clock);
         if (reset) begin
            mem_q_addr.delete();
            mem_q_due.delete();
            last_due = 0;
         end else if (mif.mem_req && mif.mem_ready) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q_addr.push_back(mif.mem_addr);
            mem_q_due.push_back(due);
         end
         @(posedge clock);
         #2;
         if (mem_q_due.size() > 0 && mem_q_due[0] <= cyc) begin
            resp_a = mem_q_addr.pop_front();
            void'(mem_q_due.pop_front());
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = mem_data(resp_a);
         end else begin
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = 8'($urandom);
         end
         mif.mem_ready = force_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Scoreboard monitor for request addresses.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && mif.mem_req && mif.mem_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_req: got addr %0d expected no request", mif.mem_addr);
            end else begin
               mon_e = exp_q.pop_front();
               check("req_addr", 32'(mif.mem_addr), 32'(mon_e));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bit found;
      repeat (3) tick();
      @(negedge clock);
      check("rst_req", {31'h0, mif.mem_req}, 32'h0);
      check("rst_addr", 32'(mif.mem_addr), 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_underrun", {31'h0, underrun}, 32'h0);

      // Frame fetch of row 0, 1-cycle memory
      tick();
      reset = 1'b0;
      tick();
      push_row(0);
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      wait_idle(2000);
      fill_ref(0, SRC_W);
      check("queue_row0", exp_q.size(), 32'h0);
      probe(10'd10, 10'd0);
      check("color_10_0", {24'h0, color_out}, 32'h05);

      // Line event row 1 while bank 0 is displayed
      tick();
      next_y = 10'd1;
      push_row(1);
      for (int i = 0; i < 8; i++) probe(10'($urandom_range(0, 639)), 10'd1);
      wait_idle(2000);
      fill_ref(1, SRC_W);
      probe(10'd6, 10'd2);
      check("color_6_2", {24'h0, color_out}, 32'h43);
      for (int i = 0; i < 16; i++) probe(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1) * 2));

      // Backpressure on the first request of row 2
      seed = 8'($urandom);
      force_low = 1'b1;
      tick();
      next_y = 10'd3;
      push_row(2);
      wait_req(10);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clock);
         check("hold_req", {31'h0, mif.mem_req}, 32'h1);
         check("hold_addr", 32'(mif.mem_addr), 32'd640);
      end
      tick();
      force_low = 1'b0;
      rand_ready = 1'b1;
      wait_idle(4000);
      rand_ready = 1'b0;
      fill_ref(2, SRC_W);
      for (int i = 0; i < 6; i++) probe(10'($urandom_range(0, 700)), 10'd4);

      // Slow memory, row 3 needed before its fetch ends
      seed = 8'($urandom);
      lat = 6;
      tick();
      next_y = 10'd5;
      push_row(3);
      tick();
      tick();
      next_y = 10'd6;
      tick();
      @(negedge clock);
      check("underrun_set", {31'h0, underrun}, 32'h1);
      wait_idle(5000);
      check("underrun_sticky", {31'h0, underrun}, 32'h1);
      check("queue_row3", exp_q.size(), 32'h0);
      fill_ref(3, SRC_W);
      for (int i = 0; i < 4; i++) probe(10'($urandom_range(0, 639)), 10'd6);

      // FRAME while waiting on row 5 col 100
      seed = 8'($urandom);
      lat = 4;
      tick();
      next_y = 10'd9;
      push_row(5);
      found = 1'b0;
      n = 0;
      while (!found && n < 3000) begin
         @(negedge clock);
         n++;
         if (mif.mem_req && mif.mem_ready && mif.mem_addr == ADDR_W'(5 * SRC_W + 100)) found = 1'b1;
      end
      check("abort_point", {31'h0, found}, 32'h1);
      tick();
      vsync = 1'b0;
      exp_q.delete();
      push_row(0);
      tick();
      vsync = 1'b1;
      wait_idle(3000);
      fill_ref(5, 100);
      fill_ref(0, SRC_W);
      probe(10'd198, 10'd10);
      probe(10'd200, 10'd10);
      for (int i = 0; i < 6; i++) probe(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1) * 10));

      // Reset while a request is pending
      lat = 1;
      force_low = 1'b1;
      tick();
      next_y = 10'd11;
      wait_req(10);
      tick();
      reset = 1'b1;
      next_y = 10'd0;
      tick();
      @(negedge clock);
      check("rstmid_req", {31'h0, mif.mem_req}, 32'h0);
      check("rstmid_busy", {31'h0, busy}, 32'h0);
      check("rstmid_underrun", {31'h0, underrun}, 32'h0);
      tick();
      reset = 1'b0;
      force_low = 1'b0;
      repeat (20) tick();
      check("rstmid_idle", {31'h0, busy}, 32'h0);
      check("queue_final", exp_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
